// File: rtl/rip_branch_history_queue.sv
// rip_branch_history_queue
//   In-order queue of predicted branches sitting between fetch and execute.
//   Fetch pushes a prediction snapshot {index, weight, pred}. Execute
//   resolves the oldest branch. One cycle after each resolve that is
//   accepted, the queue emits a predictor update strobe carrying that
//   entry, plus a mispredict pulse when the resolved direction differs
//   from the stored prediction.
//
//   Optional feature: define RIP_BHQ_MISPREDICT_FLUSH_EN so that a
//   mispredicted resolve also flushes every younger entry. A push in the
//   same cycle is dropped and does not set overflow. Without the macro,
//   younger entries are kept and only the pulse is raised.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   stall                         freezes the queue for the cycle
//   push, push_index/weight/pred  enqueue request and prediction snapshot
//   resolve_valid, resolve_actual resolve the head entry with its direction
//   update, update_index/weight,  registered predictor update payload,
//   actual, mispredict              valid the cycle after a pop
//   full, empty, count            occupancy, derived from the pointers only
//   overflow, underflow           sticky error flags
module rip_branch_history_queue #(
  parameter int DEPTH    = 8,
  parameter int INDEX_W  = 8,
  parameter int WEIGHT_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  input  logic                       push,
  input  logic [INDEX_W-1:0]         push_index,
  input  logic [WEIGHT_W-1:0]        push_weight,
  input  logic                       push_pred,
  input  logic                       resolve_valid,
  input  logic                       resolve_actual,
  output logic                       update,
  output logic [INDEX_W-1:0]         update_index,
  output logic [WEIGHT_W-1:0]        update_weight,
  output logic                       actual,
  output logic                       mispredict,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int EW = INDEX_W + WEIGHT_W + 1;

  logic [EW-1:0]       mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;

  logic [EW-1:0]       head_p0;
  logic [INDEX_W-1:0]  head_index_p0;
  logic [WEIGHT_W-1:0] head_weight_p0;
  logic                head_pred_p0;

  logic                pop_p0;
  logic                mis_p0;
  logic                flush_p0;
  logic                push_ok_p0;
  logic                ovf_set_p0;
  logic                unf_set_p0;

  // Stage p0: occupancy from the registered pointers, and the accept decisions
  assign head_p0        = mem[rd_ptr[AW-1:0]];
  assign head_index_p0  = head_p0[EW-1 -: INDEX_W];
  assign head_weight_p0 = head_p0[WEIGHT_W:1];
  assign head_pred_p0   = head_p0[0];

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  // Same slot with differing wrap bits means the writer is a full lap ahead.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  always_comb begin
    pop_p0     = 1'b0;
    mis_p0     = 1'b0;
    push_ok_p0 = 1'b0;
    ovf_set_p0 = 1'b0;
    unf_set_p0 = 1'b0;
    if (!stall) begin
      // empty is sampled before the push, so a push cannot rescue a resolve.
      pop_p0     = resolve_valid && !empty;
      mis_p0     = pop_p0 && (head_pred_p0 != resolve_actual);
      unf_set_p0 = resolve_valid && empty;
      // A pop in the same cycle frees a slot, so a push into a full queue still fits.
      push_ok_p0 = push && (!full || pop_p0) && !flush_p0;
      ovf_set_p0 = push && full && !pop_p0;
    end
  end

`ifdef RIP_BHQ_MISPREDICT_FLUSH_EN
  assign flush_p0 = mis_p0;
`else
  assign flush_p0 = 1'b0;
`endif

  // Stage p0 -> p1: storage write; storage contents are never reset
  always_ff @(posedge clk) begin
    if (push_ok_p0) begin
      mem[wr_ptr[AW-1:0]] <= {push_index, push_weight, push_pred};
    end
  end

  // Stage p0 -> p1: pointers, sticky flags and registered update payload
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      update        <= 1'b0;
      mispredict    <= 1'b0;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
      update_index  <= '0;
      update_weight <= '0;
      actual        <= 1'b0;
    end else begin
      update     <= pop_p0;
      mispredict <= mis_p0;
      if (push_ok_p0) wr_ptr <= wr_ptr + PW'(1);
      // A flush moves the read pointer onto the write pointer. The flush
      // also suppresses the push, so wr_ptr is unchanged this cycle.
      if (flush_p0)    rd_ptr <= wr_ptr;
      else if (pop_p0) rd_ptr <= rd_ptr + PW'(1);
      if (ovf_set_p0) overflow  <= 1'b1;
      if (unf_set_p0) underflow <= 1'b1;
      if (pop_p0) begin
        update_index  <= head_index_p0;
        update_weight <= head_weight_p0;
        actual        <= resolve_actual;
      end
    end
  end

endmodule

// File: tb/tb_rip_branch_history_queue.sv
// Self-checking bench for rip_branch_history_queue (DEPTH=8).
// A queue-based reference model predicts every registered output, and one
// compare process checks the DUT against it on each falling edge. Directed
// scenarios add literal expectations that pin the model itself.
module tb_rip_branch_history_queue;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, stall, push, push_pred, resolve_valid, resolve_actual;
  logic [7:0] push_index;
  logic [1:0] push_weight;
  logic       update, actual, mispredict, full, empty, overflow, underflow;
  logic [7:0] update_index;
  logic [1:0] update_weight;
  logic [3:0] count;

  rip_branch_history_queue #(.DEPTH(DEPTH), .INDEX_W(8), .WEIGHT_W(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .push(push),
    .push_index(push_index), .push_weight(push_weight), .push_pred(push_pred),
    .resolve_valid(resolve_valid), .resolve_actual(resolve_actual),
    .update(update), .update_index(update_index), .update_weight(update_weight),
    .actual(actual), .mispredict(mispredict), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, a, e, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] idx; logic [1:0] w; logic p; } ent_t;
  ent_t       m_q[$];
  ent_t       m_e;
  bit         m_upd, m_mis, m_act, m_ovf, m_unf, m_popped, m_flush, m_wfull, m_wempty;
  logic [7:0] m_idx;
  logic [1:0] m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_upd = 0; m_mis = 0; m_act = 0; m_ovf = 0; m_unf = 0;
      m_idx = '0; m_w = '0;
    end else begin
      m_upd = 0; m_mis = 0; m_popped = 0; m_flush = 0;
      if (!stall) begin
        m_wempty = (m_q.size() == 0);
        m_wfull  = (m_q.size() == DEPTH);
        if (resolve_valid) begin
          if (m_wempty) m_unf = 1;
          else begin
            m_e = m_q.pop_front();
            m_upd = 1; m_popped = 1;
            m_idx = m_e.idx; m_w = m_e.w; m_act = resolve_actual;
            m_mis = (m_e.p != resolve_actual);
`ifdef RIP_BHQ_MISPREDICT_FLUSH_EN
            if (m_mis) begin m_q.delete(); m_flush = 1; end
`endif
          end
        end
        if (push && !m_flush) begin
          if (m_wfull && !m_popped) m_ovf = 1;
          else m_q.push_back({push_index, push_weight, push_pred});
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",      32'(count),         32'(m_q.size()));
      chk("empty",      32'(empty),         32'(m_q.size() == 0));
      chk("full",       32'(full),          32'(m_q.size() == DEPTH));
      chk("update",     32'(update),        32'(m_upd));
      chk("mispredict", 32'(mispredict),    32'(m_mis));
      chk("upd_index",  32'(update_index),  32'(m_idx));
      chk("upd_weight", 32'(update_weight), 32'(m_w));
      chk("actual",     32'(actual),        32'(m_act));
      chk("overflow",   32'(overflow),      32'(m_ovf));
      chk("underflow",  32'(underflow),     32'(m_unf));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit r, input bit st, input bit p, input logic [7:0] pi,
                     input logic [1:0] pw, input bit pp, input bit rv, input bit ra);
    rst = r; stall = st; push = p; push_index = pi; push_weight = pw; push_pred = pp;
    resolve_valid = rv; resolve_actual = ra;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 2'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 8'h00, 2'd0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    do_reset();
    chk_en = 1'b1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_full",  32'(full), 0);
    chk("rst_update", 32'(update), 0);

    // single entry with mispredict
    cyc(0, 0, 1, 8'h3C, 2'd2, 1, 0, 0);
    cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, 0);
    chk("se_update", 32'(update), 1);
    chk("se_index",  32'(update_index), 32'h3C);
    chk("se_weight", 32'(update_weight), 2);
    chk("se_actual", 32'(actual), 0);
    chk("se_misp",   32'(mispredict), 1);
    idle();
    chk("se_pulse_end", 32'(update), 0);
    chk("se_hold_idx",  32'(update_index), 32'h3C);

    // fill, overflow and wrap
    for (int i = 0; i < 9; i++) begin
      cyc(0, 0, 1, 8'(8'h10 + i), 2'(i % 4), i[0], 0, 0);
      if (i == 7) chk("fill_full", 32'(full), 1);
    end
    chk("fill_ovf",   32'(overflow), 1);
    chk("fill_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, i[0]);
      chk("wrap_order", 32'(update_index), 32'(8'h10 + i));
    end
    chk("wrap_empty", 32'(empty), 1);
    idle();

    // push and pop together while full
    do_reset();
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 8'(8'h20 + i), 2'd1, 0, 0, 0);
    cyc(0, 0, 1, 8'h55, 2'd3, 0, 1, 0);
    chk("pp_count", 32'(count), 8);
    chk("pp_ovf",   32'(overflow), 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, 0);
    chk("pp_last", 32'(update_index), 32'h55);
    chk("pp_last_w", 32'(update_weight), 3);

    // stall and underflow
    cyc(0, 0, 1, 8'hA1, 2'd0, 1, 0, 0);
    cyc(0, 0, 1, 8'hA2, 2'd1, 1, 0, 0);
    cyc(0, 1, 1, 8'hA3, 2'd2, 1, 1, 1);
    chk("stall_count",  32'(count), 2);
    chk("stall_update", 32'(update), 0);
    cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, 1);
    cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, 1);
    chk("stall_drain_idx", 32'(update_index), 32'hA2);
    cyc(0, 0, 1, 8'hB0, 2'd2, 0, 1, 0);
    chk("unf_flag",  32'(underflow), 1);
    chk("unf_count", 32'(count), 1);
    chk("unf_noupd", 32'(update), 0);

    // mispredict on the head of four entries
    do_reset();
    cyc(0, 0, 1, 8'hC0, 2'd1, 1, 0, 0);
    for (int i = 1; i < 4; i++) cyc(0, 0, 1, 8'(8'hC0 + i), 2'd0, 0, 0, 0);
    cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, 0);
    chk("fl_misp", 32'(mispredict), 1);
`ifdef RIP_BHQ_MISPREDICT_FLUSH_EN
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
`else
    chk("fl_count", 32'(count), 3);
    chk("fl_empty", 32'(empty), 0);
`endif
    // mispredict with a simultaneous push
    cyc(0, 0, 1, 8'hD0, 2'd0, 0, 0, 0);
    cyc(0, 0, 1, 8'hD1, 2'd0, 1, 1, 1);
    idle();

    // reset mid-operation with a pending pop and a set underflow flag
    do_reset();
    cyc(0, 0, 0, 8'h00, 2'd0, 0, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'hE0 + i), 2'd2, 1, 0, 0);
    cyc(1, 1, 1, 8'hEF, 2'd0, 0, 1, 0);
    chk("mr_update", 32'(update), 0);
    chk("mr_count",  32'(count), 0);
    chk("mr_ovf",    32'(overflow), 0);
    chk("mr_unf",    32'(underflow), 0);
    idle();
    idle();

    chk_en = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rip_branch_history_queue.md
RIP_BRANCH_HISTORY_QUEUE -- requirements
Module: rip_branch_history_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of in-flight branch entries; it is a power of two, 2..64.
REQ-002 SHALL have parameter INDEX_W, default 8, meaning the predictor table index width.
REQ-003 SHALL have parameter WEIGHT_W, default 2, meaning the predictor counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port stall, input, 1 bit: pipeline stall that freezes the queue.
REQ-007 SHALL have port push, input, 1 bit: the fetch stage enqueues a predicted branch.
REQ-008 SHALL have ports push_index (input, INDEX_W), push_weight (input, WEIGHT_W) and push_pred (input, 1), carrying the prediction snapshot.
REQ-009 SHALL have port resolve_valid, input, 1 bit: the execute stage resolves the oldest branch.
REQ-010 SHALL have port resolve_actual, input, 1 bit: the resolved direction (1 = taken).
REQ-011 SHALL have port update, output, 1 bit: the predictor update strobe.
REQ-012 SHALL have ports update_index (output, INDEX_W), update_weight (output, WEIGHT_W) and actual (output, 1), carrying the predictor update payload.
REQ-013 SHALL have port mispredict, output, 1 bit: pulses when the resolved direction differs from the stored push_pred.
REQ-014 SHALL have ports full (output, 1), empty (output, 1) and count (output, clog2(DEPTH)+1 bits).
REQ-015 SHALL have ports overflow and underflow, outputs, 1 bit each, as sticky error flags.

Function
REQ-016 SHALL operate as an in-order circular FIFO; read and write pointers are clog2(DEPTH)+1 bits, and the extra MSB distinguishes full from empty on wrap-around.
REQ-017 SHALL treat the cycle as frozen when stall=1: push and resolve_valid are ignored, no state changes, and update=0 and mispredict=0 on the next cycle.
REQ-018 SHALL, when push=1 and not full (or when full with an accepted pop in the same cycle), write {push_index, push_weight, push_pred} at the write pointer and advance it.
REQ-019 SHALL, when push=1, the queue is full and there is no accepted pop, drop the entry and set overflow.
REQ-020 SHALL, when resolve_valid=1 and the queue is not empty, pop the head entry.
REQ-021 SHALL evaluate empty before the same-cycle push, so resolve_valid=1 while empty is ignored even with a simultaneous push, and sets underflow.
REQ-022 SHALL, on the cycle after an accepted pop, hold update=1 for exactly one cycle with update_index/update_weight equal to the popped entry and actual equal to the registered resolve_actual.
REQ-023 SHALL hold mispredict=1 for one cycle, in the same cycle as update, when resolve_actual differs from the stored pred.
REQ-024 SHALL hold update_index/update_weight/actual at their last value when update=0.
REQ-025 SHALL derive full, empty and count from the registered pointers only, with no combinational path from push or resolve_valid.
REQ-026 SHALL keep count in 0..DEPTH, incrementing by 1 on push only, decrementing by 1 on pop only, and leaving it unchanged on push plus pop.

Reset
REQ-027 SHALL, on any cycle with rst=1, clear both pointers, count, update, mispredict, overflow and underflow, and set empty=1 and full=0.
REQ-028 SHALL give rst priority over stall, push and resolve_valid; a reset mid-operation discards all entries and any pending update.
REQ-029 SHALL reset update_index, update_weight and actual to 0; storage contents are not reset.

Configuration
REQ-030 SHALL, when macro RIP_BHQ_MISPREDICT_FLUSH_EN is defined, flush all remaining entries on an accepted pop whose direction mismatches, so that count=0 and empty=1 the next cycle and a same-cycle push is dropped without setting overflow.
REQ-031 SHALL, when RIP_BHQ_MISPREDICT_FLUSH_EN is undefined, only assert the mispredict pulse and retain all younger entries.

Verification
REQ-032 SHALL cover a single entry: after reset, push index=0x3C weight=2 pred=1, then resolve actual=0 -> one cycle later update=1, update_index=0x3C, update_weight=2, actual=0, mispredict=1.
REQ-033 SHALL cover fill, overflow and wrap: push 9 entries with DEPTH=8 -> full=1 after 8, overflow=1 and count=8; then 8 pops -> updates return entries 0..7 in order, empty=1, and the pointers have wrapped.
REQ-034 SHALL cover push plus pop while full: full queue, push=1 and resolve_valid=1 -> count stays 8, overflow stays 0, and the new entry is returned last.
REQ-035 SHALL cover stall and underflow: stall=1 with push and resolve -> count unchanged and update=0; resolve on empty with push -> underflow=1 and count=1.
REQ-036 SHALL cover a flush with RIP_BHQ_MISPREDICT_FLUSH_EN: 4 entries, head pred=1, resolve actual=0 -> mispredict=1 and count=0 next cycle; without the macro -> count=3.
REQ-037 SHALL cover reset mid-operation: rst=1 for one cycle with 5 entries and a pending pop -> update=0 next cycle, count=0, overflow=0 and underflow=0.
